// File: rtl/stream_pair_aligner_if.sv
// Operand streams A and B into the aligner, and the aligned pair stream out of it.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready; a source holds
// tdata/tlast stable while tvalid is high and tready is low, and tvalid never waits on tready.
interface stream_pair_aligner_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a_tdata;
  logic             a_tlast;
  logic             a_tvalid;
  logic             a_tready;
  logic [WIDTH-1:0] b_tdata;
  logic             b_tlast;
  logic             b_tvalid;
  logic             b_tready;
  logic [WIDTH-1:0] o_a_tdata;
  logic [WIDTH-1:0] o_b_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport slave (
    input  a_tdata, a_tlast, a_tvalid,
    output a_tready,
    input  b_tdata, b_tlast, b_tvalid,
    output b_tready,
    output o_a_tdata, o_b_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

  modport master (
    output a_tdata, a_tlast, a_tvalid,
    input  a_tready,
    output b_tdata, b_tlast, b_tvalid,
    input  b_tready,
    input  o_a_tdata, o_b_tdata, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/stream_pair_aligner.sv
// Buffers operand streams A and B and releases them as lock-step pairs; a packet-length
// mismatch drains both packets to their last words and resumes at the next packet start.
module stream_pair_aligner #(
  parameter int WIDTH     = 32,
  parameter int FIFO_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  stream_pair_aligner_if.slave bus,
  output logic [15:0]          mismatch_count,
  output logic                 state_dbg
);

  localparam int DEPTH = 1 << FIFO_SIZE;

  typedef enum logic {ALIGNED = 1'b0, DRAIN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [15:0]        mismatch_count_q, mismatch_count_d;
  logic [FIFO_SIZE:0] wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [FIFO_SIZE:0] wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic               rdy_en_q;
  logic [WIDTH:0]     mem_a_q [DEPTH];
  logic [WIDTH:0]     mem_b_q [DEPTH];

  logic [WIDTH:0] head_a, head_b;
  logic           empty_a, empty_b, full_a, full_b;
  logic           push_a, push_b, pop_a, pop_b;
  logic           both_avail, lasts_match, o_valid;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_a = (wr_a_q == rd_a_q);
  assign empty_b = (wr_b_q == rd_b_q);
  assign full_a  = (wr_a_q[FIFO_SIZE] != rd_a_q[FIFO_SIZE]) &&
                   (wr_a_q[FIFO_SIZE-1:0] == rd_a_q[FIFO_SIZE-1:0]);
  assign full_b  = (wr_b_q[FIFO_SIZE] != rd_b_q[FIFO_SIZE]) &&
                   (wr_b_q[FIFO_SIZE-1:0] == rd_b_q[FIFO_SIZE-1:0]);
  assign head_a  = mem_a_q[rd_a_q[FIFO_SIZE-1:0]];
  assign head_b  = mem_b_q[rd_b_q[FIFO_SIZE-1:0]];

  assign bus.a_tready = rdy_en_q & ~full_a;
  assign bus.b_tready = rdy_en_q & ~full_b;
  assign push_a       = bus.a_tvalid & bus.a_tready & ~clear;
  assign push_b       = bus.b_tvalid & bus.b_tready & ~clear;

  assign both_avail  = ~empty_a & ~empty_b;
  assign lasts_match = (head_a[WIDTH] == head_b[WIDTH]);
  assign o_valid     = (state_q == ALIGNED) & both_avail & lasts_match;

  assign bus.o_tvalid  = o_valid;
  assign bus.o_tlast   = o_valid & head_a[WIDTH];
  assign bus.o_a_tdata = o_valid ? head_a[WIDTH-1:0] : '0;
  assign bus.o_b_tdata = o_valid ? head_b[WIDTH-1:0] : '0;

  assign mismatch_count = mismatch_count_q;
  assign state_dbg      = (state_q == DRAIN);

  always_comb begin
    state_d          = state_q;
    mismatch_count_d = mismatch_count_q;
    pop_a            = 1'b0;
    pop_b            = 1'b0;
    case (state_q)
      ALIGNED: begin
        if (both_avail) begin
          if (lasts_match) begin
            pop_a = bus.o_tready;
            pop_b = bus.o_tready;
          end else begin
            state_d = DRAIN;
            if (mismatch_count_q != 16'hFFFF) mismatch_count_d = mismatch_count_q + 16'd1;
          end
        end
      end
      default: begin
        // The shorter packet parks on its last word until the longer one catches up.
        if (both_avail && head_a[WIDTH] && head_b[WIDTH]) begin
          pop_a   = 1'b1;
          pop_b   = 1'b1;
          state_d = ALIGNED;
        end else begin
          pop_a = ~empty_a & ~head_a[WIDTH];
          pop_b = ~empty_b & ~head_b[WIDTH];
        end
      end
    endcase
    wr_a_d = wr_a_q + (FIFO_SIZE+1)'(push_a);
    wr_b_d = wr_b_q + (FIFO_SIZE+1)'(push_b);
    rd_a_d = rd_a_q + (FIFO_SIZE+1)'(pop_a);
    rd_b_d = rd_b_q + (FIFO_SIZE+1)'(pop_b);
    if (clear) begin
      state_d          = ALIGNED;
      mismatch_count_d = '0;
      wr_a_d           = '0;
      wr_b_d           = '0;
      rd_a_d           = '0;
      rd_b_d           = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ALIGNED;
      mismatch_count_q <= '0;
      wr_a_q           <= '0;
      wr_b_q           <= '0;
      rd_a_q           <= '0;
      rd_b_q           <= '0;
      rdy_en_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      mismatch_count_q <= mismatch_count_d;
      wr_a_q           <= wr_a_d;
      wr_b_q           <= wr_b_d;
      rd_a_q           <= rd_a_d;
      rd_b_q           <= rd_b_d;
      rdy_en_q         <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they were written.
  always_ff @(posedge clk) begin
    if (push_a) mem_a_q[wr_a_q[FIFO_SIZE-1:0]] <= {bus.a_tlast, bus.a_tdata};
    if (push_b) mem_b_q[wr_b_q[FIFO_SIZE-1:0]] <= {bus.b_tlast, bus.b_tdata};
  end

endmodule

// File: tb/tb_stream_pair_aligner.sv
// Self-checking bench for stream_pair_aligner: a cycle table, directed corner sequences and
// randomized packet pairs checked against a packet-level model.
module tb_stream_pair_aligner;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] mismatch_count;
  logic        state_dbg;

  stream_pair_aligner_if #(.WIDTH(W)) bus ();

  stream_pair_aligner #(.WIDTH(W), .FIFO_SIZE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .bus            (bus.slave),
    .mismatch_count (mismatch_count),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int out_first, out_last, n_extra;

  logic [W:0]   a_src_q[$];
  logic [W:0]   b_src_q[$];
  logic [2*W:0] exp_q[$];

  typedef struct {
    logic av; logic [W-1:0] ad; logic al;
    logic bv; logic [W-1:0] bd; logic bl;
    logic ordy;
    logic ev; logic [W-1:0] ea; logic [W-1:0] eb; logic el;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.a_tvalid = 1'b0; bus.a_tdata = '0; bus.a_tlast = 1'b0;
    bus.b_tvalid = 1'b0; bus.b_tdata = '0; bus.b_tlast = 1'b0;
    bus.o_tready = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    idle_inputs();
  endtask

  task automatic add_pkt(input bit to_b, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (to_b) b_src_q.push_back({(i == n - 1), W'(base + i)});
      else      a_src_q.push_back({(i == n - 1), W'(base + i)});
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    bus.a_tvalid = 1'b1; bus.a_tdata = 32'h0000_0BAD; bus.a_tlast = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle_inputs();
  endtask

  // Drives both source queues with random gaps, random o_tready, and scores every output pair.
  task automatic run_stream(input int a_dly, input int b_dly, input int vld_pct,
                            input int rdy_pct, input int budget);
    int ai = 0, bi = 0, cyc = 0;
    logic acc_a = 1'b0, acc_b = 1'b0;
    logic [2*W:0] got;
    out_first = -1; out_last = -1; n_extra = 0;
    while ((ai < a_src_q.size() || bi < b_src_q.size() || exp_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      if (acc_a) ai++;
      if (acc_b) bi++;
      bus.a_tvalid = (cyc >= a_dly) && (ai < a_src_q.size()) && ($urandom_range(99) < vld_pct);
      {bus.a_tlast, bus.a_tdata} = bus.a_tvalid ? a_src_q[ai] : '0;
      bus.b_tvalid = (cyc >= b_dly) && (bi < b_src_q.size()) && ($urandom_range(99) < vld_pct);
      {bus.b_tlast, bus.b_tdata} = bus.b_tvalid ? b_src_q[bi] : '0;
      bus.o_tready = ($urandom_range(99) < rdy_pct);
      #1;
      acc_a = bus.a_tvalid & bus.a_tready;
      acc_b = bus.b_tvalid & bus.b_tready;
      if (bus.o_tvalid && bus.o_tready) begin
        got = {bus.o_tlast, bus.o_a_tdata, bus.o_b_tdata};
        if (exp_q.size() == 0) n_extra++;
        else check("pair", got, exp_q.pop_front());
        if (out_first < 0) out_first = cyc;
        out_last = cyc;
      end
      cyc++;
    end
    check("stream_done", {ai == a_src_q.size(), bi == b_src_q.size(), exp_q.size() == 0}, 3'b111);
    check("extra_pairs", n_extra, 0);
    a_src_q.delete(); b_src_q.delete(); exp_q.delete();
    idle_cycles(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb, m, exp_mm;
    logic [W-1:0] da, db;

    vecs[0]  = '{1, 32'd1, 0, 1, 32'd10, 0, 1,   0, 32'd0, 32'd0,  0};
    vecs[1]  = '{1, 32'd2, 0, 1, 32'd20, 0, 1,   1, 32'd1, 32'd10, 0};
    vecs[2]  = '{1, 32'd3, 0, 1, 32'd30, 0, 1,   1, 32'd2, 32'd20, 0};
    vecs[3]  = '{1, 32'd4, 1, 1, 32'd40, 1, 1,   1, 32'd3, 32'd30, 0};
    vecs[4]  = '{0, 32'd0, 0, 0, 32'd0,  0, 1,   1, 32'd4, 32'd40, 1};
    vecs[5]  = '{0, 32'd0, 0, 0, 32'd0,  0, 1,   0, 32'd0, 32'd0,  0};
    vecs[6]  = '{1, 32'd7, 1, 1, 32'd70, 1, 0,   0, 32'd0, 32'd0,  0};
    vecs[7]  = '{0, 32'd0, 0, 0, 32'd0,  0, 0,   1, 32'd7, 32'd70, 1};
    vecs[8]  = '{0, 32'd0, 0, 0, 32'd0,  0, 0,   1, 32'd7, 32'd70, 1};
    vecs[9]  = '{0, 32'd0, 0, 0, 32'd0,  0, 1,   1, 32'd7, 32'd70, 1};
    vecs[10] = '{0, 32'd0, 0, 0, 32'd0,  0, 1,   0, 32'd0, 32'd0,  0};

    reset = 1'b1;
    clear = 1'b0;
    idle_inputs();
    #3;
    check("rst_tready", {bus.a_tready, bus.b_tready}, 2'b00);
    check("rst_outputs", {bus.o_tvalid, bus.o_tlast, bus.o_a_tdata, bus.o_b_tdata,
                          mismatch_count, state_dbg}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_tready", {bus.a_tready, bus.b_tready}, 2'b11);

    // Cycle table: equal packets at full rate, then a stalled single-word packet.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.a_tvalid = vecs[i].av; bus.a_tdata = vecs[i].ad; bus.a_tlast = vecs[i].al;
      bus.b_tvalid = vecs[i].bv; bus.b_tdata = vecs[i].bd; bus.b_tlast = vecs[i].bl;
      bus.o_tready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_valid", i), bus.o_tvalid, vecs[i].ev);
      if (vecs[i].ev)
        check($sformatf("vec%0d_data", i), {bus.o_tlast, bus.o_a_tdata, bus.o_b_tdata},
              {vecs[i].el, vecs[i].ea, vecs[i].eb});
    end
    idle_cycles(1);
    check("eq_mismatch_count", mismatch_count, 0);

    // Skewed arrival: B starts 5 cycles after A.
    add_pkt(0, 3, 32'h100);
    add_pkt(1, 3, 32'h200);
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), W'(32'h100 + i), W'(32'h200 + i)});
    run_stream(0, 5, 100, 100, 200);
    check("skew_first_out", out_first, 6);
    check("skew_last_out", out_last, 8);

    // Mismatch: 5 vs 3 words, then an aligned 2-word packet.
    add_pkt(0, 5, 32'h51);
    add_pkt(0, 2, 32'h61);
    add_pkt(1, 3, 32'hB1);
    add_pkt(1, 2, 32'h71);
    exp_q.push_back({1'b0, 32'h51, 32'hB1});
    exp_q.push_back({1'b0, 32'h52, 32'hB2});
    exp_q.push_back({1'b0, 32'h61, 32'h71});
    exp_q.push_back({1'b1, 32'h62, 32'h72});
    run_stream(0, 0, 100, 100, 200);
    idle_cycles(3);
    check("mm_count", mismatch_count, 1);
    check("mm_state", state_dbg, 0);

    // Async reset asserted between edges while a pair is waiting.
    @(negedge clk);
    bus.a_tvalid = 1'b1; bus.a_tdata = 32'h11; bus.a_tlast = 1'b0;
    bus.b_tvalid = 1'b1; bus.b_tdata = 32'h22; bus.b_tlast = 1'b0;
    bus.o_tready = 1'b0;
    @(negedge clk);
    idle_inputs();
    bus.o_tready = 1'b0;
    #1;
    check("pre_rst_valid", bus.o_tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", {bus.o_tvalid, mismatch_count, bus.a_tready, bus.b_tready}, '0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    add_pkt(0, 2, 32'h300);
    add_pkt(1, 2, 32'h400);
    exp_q.push_back({1'b0, 32'h300, 32'h400});
    exp_q.push_back({1'b1, 32'h301, 32'h401});
    run_stream(0, 0, 100, 100, 200);
    check("rst_mm_count", mismatch_count, 0);

    // Backpressure: fill A completely while the output is stalled.
    bus.o_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.a_tvalid = 1'b1; bus.a_tdata = W'(100 + i); bus.a_tlast = (i == 15);
      #1;
      check($sformatf("fill%0d_ready", i), bus.a_tready, 1);
    end
    @(negedge clk);
    bus.a_tdata = 32'd999; bus.a_tlast = 1'b0;
    #1;
    check("full_a_tready", bus.a_tready, 0);
    check("full_b_tready", bus.b_tready, 1);
    check("full_no_b_valid", bus.o_tvalid, 0);
    @(negedge clk);
    bus.a_tvalid = 1'b0;
    bus.b_tvalid = 1'b1; bus.b_tdata = 32'd200; bus.b_tlast = 1'b0;
    @(negedge clk);
    bus.b_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("stall%0d", i), {bus.o_tvalid, bus.o_tlast, bus.o_a_tdata, bus.o_b_tdata},
            {1'b1, 1'b0, 32'd100, 32'd200});
      @(negedge clk);
    end
    do_clear();
    #1;
    check("clear_state", {bus.a_tready, bus.o_tvalid, mismatch_count}, {1'b1, 17'd0});
    add_pkt(0, 1, 32'h500);
    add_pkt(1, 1, 32'h600);
    exp_q.push_back({1'b1, 32'h500, 32'h600});
    run_stream(0, 0, 100, 100, 200);

    // Saturation: preload near the top, then two more mismatches.
    @(negedge clk);
    force dut.mismatch_count_d = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.mismatch_count_d;
    @(negedge clk);
    check("sat_preload", mismatch_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, 1, 32'h700);
      add_pkt(1, 2, 32'h800);
      run_stream(0, 0, 100, 100, 200);
      idle_cycles(4);
      check($sformatf("sat_count%0d", k), mismatch_count, 16'hFFFF);
    end

    // Random packet pairs against a packet-level model.
    do_clear();
    exp_mm = 0;
    for (int p = 0; p < 40; p++) begin
      la = $urandom_range(1, 6);
      lb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : la;
      m  = (la < lb) ? la : lb;
      if (la != lb) exp_mm++;
      for (int i = 0; i < ((la > lb) ? la : lb); i++) begin
        da = $urandom();
        db = $urandom();
        if (i < la) a_src_q.push_back({(i == la - 1), da});
        if (i < lb) b_src_q.push_back({(i == lb - 1), db});
        if (la == lb) exp_q.push_back({(i == la - 1), da, db});
        else if (i < m - 1) exp_q.push_back({1'b0, da, db});
      end
    end
    run_stream(0, 0, 75, 75, 5000);
    idle_cycles(6);
    check("rand_mm_count", mismatch_count, exp_mm);
    check("rand_idle", {bus.o_tvalid, state_dbg}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stream_pair_aligner.md
Name: stream_pair_aligner

Overview:
- Sits between the two CHDR deframers and a two-operand HLS compute core (add/sub style).
- Buffers operand streams A and B independently and releases them to the core only as lock-step pairs.
- Detects packet-length mismatch between A and B and resynchronises at the next packet boundary, so the core never sees a misaligned operand pair.

Parameters:
WIDTH, 32, sample width of each operand stream.
FIFO_SIZE, 4, log2 of per-input FIFO depth (default 16 entries).

Ports:
clk  in  1  compute-engine clock.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous flush of FIFOs, state and counter.
a_tdata  in  WIDTH  operand A sample.
a_tlast  in  1  last sample of A packet.
a_tvalid  in  1  A valid.
a_tready  out  1  A ready.
b_tdata  in  WIDTH  operand B sample.
b_tlast  in  1  last sample of B packet.
b_tvalid  in  1  B valid.
b_tready  out  1  B ready.
o_a_tdata  out  WIDTH  aligned operand A.
o_b_tdata  out  WIDTH  aligned operand B.
o_tlast  out  1  last pair of packet.
o_tvalid  out  1  pair valid.
o_tready  in  1  downstream ready.
mismatch_count  out  16  saturating count of resync events.
state_dbg  out  1  0 = ALIGNED, 1 = DRAIN.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFOs empty; state ALIGNED; mismatch_count = 0.
  - o_tvalid = 0, o_tlast = 0, o_a_tdata = o_b_tdata = 0.
  - a_tready = b_tready = 0 while reset is asserted; both go to 1 on the first clk edge after release.
- clear (synchronous): same effect as reset on the next edge; input handshakes presented in that cycle are discarded.
- Per-input FIFO:
  - Depth 2^FIFO_SIZE, each entry holds {tlast, tdata}.
  - x_tready = !full; push on x_tvalid & x_tready.
  - No push-through-when-full: a full FIFO deasserts tready even if it is popping that cycle.
- Latency and throughput:
  - A word pushed at edge t is at the FIFO head from cycle t+1. Minimum input-to-output latency is 1 cycle.
  - Sustained throughput is 1 pair per cycle with no bubbles.
- Heads: hA/hB are the FIFO head words; both_avail = !emptyA & !emptyB.
- State ALIGNED:
  - If both_avail and hA.tlast == hB.tlast:
    - o_tvalid = 1; o_a_tdata = hA.data; o_b_tdata = hB.data; o_tlast = hA.tlast.
    - Pop both FIFOs on o_tvalid & o_tready.
  - If both_avail and hA.tlast != hB.tlast:
    - o_tvalid = 0; mismatch_count increments, saturating at 0xFFFF.
    - Next state is DRAIN.
  - If a head is missing: o_tvalid = 0.
- State DRAIN (o_tvalid held 0):
  - Each cycle, pop and discard the head of any non-empty FIFO whose head tlast = 0.
  - Once both heads have tlast = 1, pop both in the same cycle (discard) and return to ALIGNED on the next cycle.
  - The shorter packet's last word is held in its FIFO, not popped, until the other stream reaches its last word.
- Output stability: while o_tvalid = 1 and o_tready = 0, o_a_tdata, o_b_tdata and o_tlast hold stable.
- Outputs: o_* are combinational from FIFO heads and state; no combinational path from a_tvalid/b_tvalid to o_tvalid.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy is unchanged.
- Reset or clear mid-packet or in DRAIN: all buffered data is lost; the next accepted words are treated as packet starts.

Test Plan:
1. Equal packets, A = 1,2,3,4 and B = 10,20,30,40 (last on 4th), o_tready = 1 -> 4 pairs (1,10)..(4,40) on consecutive cycles; o_tlast only on (4,40); first o_tvalid 1 cycle after first handshake; mismatch_count = 0.
2. Skewed arrival: A packet of 3 sent, B sent 5 cycles later -> no o_tvalid until B head present, then 3 back-to-back pairs; no data loss.
3. Mismatch: A = 5 words, B = 3 words, followed by an aligned 2-word packet on both -> first 2 pairs emitted; DRAIN discards the remainder of both packets; mismatch_count = 1; the 2-word packet is then emitted intact with o_tlast on its 2nd pair.
4. Backpressure and full: o_tready = 0, push 16 words on A -> a_tready drops after the 16th; b_tready stays 1; o_tvalid asserts as soon as B has data; output data stable for 10 stalled cycles.
5. Async reset asserted mid-packet between edges -> o_tvalid, mismatch_count and the ready signals go to 0 immediately; after release, a fresh 2-word packet pair is emitted correctly.
6. Counter saturation: force 65536 mismatches (or preload via backdoor to 0xFFFE, then cause 2 mismatches) -> mismatch_count holds at 0xFFFF.
